// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder, reused once per cycle by the serial adder datapath.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    sum  = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {C_out, s} = a + b + C_in over WIDTH clocks, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow output ovf.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; operands latched when start is seen
// ST_SHIFT | one sum bit per cycle through the shared full-adder cell
// ST_DONE  | done pulse; s/C_out already hold the new result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             C_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb;
  // Holds the WIDTH-1 sum bits produced so far; the live sum bit completes the result.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_full;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             load;
  logic             shift_en;
  logic             fa_sum;
  logic             fa_cout;

  full_adder_cell u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign sr_full  = {fa_sum, sr};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and control strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand shift registers, running carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      sa    <= a;
      sb    <= b;
      sr    <= '0;
      carry <= C_in;
      cnt   <= '0;
    end else if (shift_en) begin
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      sr    <= sr_full[WIDTH-1:1];
      carry <= fa_cout;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result registers, updated only on the edge that enters ST_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= '0;
      C_out <= 1'b0;
    end else if (shift_en && last_bit) begin
      s     <= sr_full;
      C_out <= fa_cout;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf <= 1'b0;
    else if (shift_en && last_bit) ovf <= carry ^ fa_cout;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a monitor pops on done.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             C_in;
  logic             busy, done;
  logic [WIDTH-1:0] s;
  logic             C_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] held_s = '0;
  logic             held_c = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .C_out (C_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for s/C_out, two's complement range for ovf.
  function automatic exp_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                 input logic ci);
    exp_t e;
    int   tot, sa_i, sb_i, sv;
    tot  = int'(ai) + int'(bi) + int'(ci);
    e.s  = WIDTH'(tot % (2 ** WIDTH));
    e.c  = (tot >= 2 ** WIDTH);
    sa_i = (int'(ai) >= 2 ** (WIDTH - 1)) ? int'(ai) - 2 ** WIDTH : int'(ai);
    sb_i = (int'(bi) >= 2 ** (WIDTH - 1)) ? int'(bi) - 2 ** WIDTH : int'(bi);
    sv   = sa_i + sb_i + int'(ci);
    e.ovf = (sv > 2 ** (WIDTH - 1) - 1) || (sv < -(2 ** (WIDTH - 1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 32'(s), 32'(e.s));
        check("carry_out", 32'(C_out), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Issue one operation from an idle DUT; returns just after the start edge.
  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci);
    check("idle_before_start", 32'(busy), 32'd0);
    a = ai; b = bi; C_in = ci; start = 1'b1;
    exp_q.push_back(model(ai, bi, ci));
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); C_in = 1'($urandom);
  endtask

  // Wait for done with a cycle budget; optionally pulse start while busy at cycle restart_at.
  task automatic finish_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                           input logic ci, input int restart_at);
    exp_t e;
    int   lat;
    e   = model(ai, bi, ci);
    lat = 0;
    while (!done && lat < 20) begin
      check("busy_during_op", 32'(busy), 32'd1);
      check("s_held_during_op", 32'(s), 32'(held_s));
      if (lat == restart_at) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'(WIDTH));
    check("busy_at_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("s_holds_after", 32'(s), 32'(e.s));
    check("c_holds_after", 32'(C_out), 32'(e.c));
    held_s = e.s;
    held_c = e.c;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci);
    issue(ai, bi, ci);
    finish_op(ai, bi, ci, -1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; C_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", 32'(s), 32'd0);
    check("rst_c", 32'(C_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_after_release", 32'(busy | done), 32'd0);
    end

    run_op(4'd7, 4'd4, 1'b0);
    run_op(4'd14, 4'd12, 1'b0);
    run_op(4'd15, 4'd15, 1'b1);
    run_op(4'd0, 4'd0, 1'b0);

    // start pulsed while busy must be ignored, not queued
    issue(4'd2, 4'd15, 1'b1);
    finish_op(4'd2, 4'd15, 1'b1, 1);
    repeat (4) begin
      @(posedge clk); #1;
      check("no_queued_start", 32'(busy), 32'd0);
    end

    // reset in the middle of an operation aborts it silently
    issue(4'd9, 4'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_s", 32'(s), 32'd0);
    check("abort_c", 32'(C_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", 32'(ovf), 32'd0);
`endif
    exp_q.delete();
    held_s = '0; held_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      check("no_done_after_abort", 32'(busy | done), 32'd0);
    end
    run_op(4'd6, 4'd9, 1'b1);

    // signed-overflow corner cases
    run_op(4'd7, 4'd1, 1'b0);
    run_op(4'd8, 4'd8, 1'b0);
    run_op(4'd5, 4'd4, 1'b0);
    run_op(4'd3, 4'd2, 1'b0);

    // random operands, some with idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
